// File: rtl/histogram_pkg.sv
// Shared constants and types for the histogram / CDF pipeline stages.
//   NBINS, ADDR_W, DATA_W : default geometry of the histogram RAM
//   ST_*                  : CDF sweep FSM state encoding
//   bin_addr_t, bin_cnt_t : bin address and bin count / CDF entry types
package histogram_pkg;

   localparam int unsigned NBINS  = 256;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 32;

   localparam int unsigned ST_W = 2;
   localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
   localparam logic [ST_W-1:0] ST_RUN   = 2'd1;
   localparam logic [ST_W-1:0] ST_DRAIN = 2'd2;
   localparam logic [ST_W-1:0] ST_DONE  = 2'd3;

   typedef logic [ADDR_W-1:0] bin_addr_t;
   typedef logic [DATA_W-1:0] bin_cnt_t;

endpackage

// File: rtl/histogram_cdf_addr_gen.sv
// Bin address generator for the CDF sweep.
//   clk, rst  : clock, asynchronous active-low reset
//   load_i    : clear the bin counter to 0 (sweep start)
//   en_i      : issue the current address this cycle and advance
//   addr_o    : registered read address (0 when idle)
//   waddr_o   : address issued one cycle earlier (write address), 0 otherwise
//   last_c_o  : current address is the final bin (combinational)
//   rvalid_o  : read data for waddr_o is present this cycle
module histogram_cdf_addr_gen #(
   parameter int unsigned NBINS  = histogram_pkg::NBINS,
   parameter int unsigned ADDR_W = histogram_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              en_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic [ADDR_W-1:0] waddr_o,
   output logic              last_c_o,
   output logic              rvalid_o
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic              rvalid_q, rvalid_d;

   assign last_c_o = (addr_q == ADDR_W'(NBINS - 1));

   // Counter returns to 0 after the final bin so the read address idles at 0.
   always_comb begin
      addr_d   = addr_q;
      waddr_d  = '0;
      rvalid_d = 1'b0;
      if (load_i) begin
         addr_d = '0;
      end else if (en_i) begin
         addr_d = last_c_o ? '0 : addr_q + ADDR_W'(1);
      end
      if (en_i) begin
         waddr_d  = addr_q;
         rvalid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q   <= '0;
         waddr_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         addr_q   <= addr_d;
         waddr_q  <= waddr_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign addr_o   = addr_q;
   assign waddr_o  = waddr_q;
   assign rvalid_o = rvalid_q;

endmodule

// File: rtl/histogram_cdf.sv
// Histogram-to-CDF stage: on start, sweeps the histogram RAM (arg_0) in bin
// order and writes the running prefix sum to the CDF RAM (arg_1), then holds
// the grand total with valid high until the next accepted start.
//   clk, rst          : clock, asynchronous active-low reset
//   start             : sweep request, accepted in IDLE or DONE
//   valid, total      : sweep complete / sum of all bins (mod 2^DATA_W)
//   arg_0_raddr_0     : histogram read address; arg_0_rdata_0 arrives 1 cycle later
//   arg_0_w*_0        : histogram write port (bin clearing)
//   arg_1_w*_0        : CDF RAM write port
// Build option: define HISTOGRAM_CDF_CLEAR_EN to zero each histogram bin as it
// is consumed; otherwise the histogram write port is tied off.
module histogram_cdf #(
   parameter int unsigned NBINS  = histogram_pkg::NBINS,
   parameter int unsigned ADDR_W = histogram_pkg::ADDR_W,
   parameter int unsigned DATA_W = histogram_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              valid,
   output logic [DATA_W-1:0] total,
   output logic [ADDR_W-1:0] arg_0_raddr_0,
   input  logic [DATA_W-1:0] arg_0_rdata_0,
   output logic [ADDR_W-1:0] arg_0_waddr_0,
   output logic [DATA_W-1:0] arg_0_wdata_0,
   output logic              arg_0_wen_0,
   output logic [ADDR_W-1:0] arg_1_waddr_0,
   output logic [DATA_W-1:0] arg_1_wdata_0,
   output logic              arg_1_wen_0
);
   import histogram_pkg::*;

   logic [ST_W-1:0]   state_q, state_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] total_q, total_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] sum_c;
   logic              start_acc_c;
   logic              run_c;
   logic              last_c;
   logic              rvalid;
   logic [ADDR_W-1:0] waddr;

   assign run_c = (state_q == ST_RUN);
   assign sum_c = acc_q + arg_0_rdata_0;

   histogram_cdf_addr_gen #(
      .NBINS  (NBINS),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk      (clk),
      .rst      (rst),
      .load_i   (start_acc_c),
      .en_i     (run_c),
      .addr_o   (arg_0_raddr_0),
      .waddr_o  (waddr),
      .last_c_o (last_c),
      .rvalid_o (rvalid)
   );

   // Sweep control, accumulator and result capture.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      total_d     = total_q;
      valid_d     = valid_q;
      start_acc_c = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d     = ST_RUN;
               start_acc_c = 1'b1;
               acc_d       = '0;
               valid_d     = 1'b0;
            end
         end
         ST_RUN: begin
            if (last_c) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Final bin returns this cycle, so capture the completed sum directly.
            state_d = ST_DONE;
            total_d = sum_c;
            valid_d = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Never overlaps the start branch: read data only returns in RUN/DRAIN.
      if (rvalid) begin
         acc_d = sum_c;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         total_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         total_q <= total_d;
         valid_q <= valid_d;
      end
   end

   assign valid = valid_q;
   assign total = total_q;

   // CDF write data is the same-cycle sum of the returning bin.
   assign arg_1_wen_0   = rvalid;
   assign arg_1_waddr_0 = waddr;
   assign arg_1_wdata_0 = rvalid ? sum_c : '0;

`ifdef HISTOGRAM_CDF_CLEAR_EN
   // Write address trails the read address by one, so no read/write hazard.
   assign arg_0_wen_0   = rvalid;
   assign arg_0_waddr_0 = waddr;
   assign arg_0_wdata_0 = '0;
`else
   assign arg_0_wen_0   = 1'b0;
   assign arg_0_waddr_0 = '0;
   assign arg_0_wdata_0 = '0;
`endif

endmodule

// File: tb/tb_histogram_cdf.sv
// Self-checking bench for histogram_cdf: behavioural RAMs, a cycle-relative
// reference model of the sweep, a per-cycle output compare, and directed plus
// randomized sweeps.
module tb_histogram_cdf;
   import histogram_pkg::*;

   localparam int NB = int'(NBINS);

   logic      clk;
   logic      rst;
   logic      start;
   logic      valid;
   bin_cnt_t  total;
   bin_addr_t arg_0_raddr_0;
   bin_cnt_t  arg_0_rdata_0;
   bin_addr_t arg_0_waddr_0;
   bin_cnt_t  arg_0_wdata_0;
   logic      arg_0_wen_0;
   bin_addr_t arg_1_waddr_0;
   bin_cnt_t  arg_1_wdata_0;
   logic      arg_1_wen_0;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   logic chk_en   = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   histogram_cdf dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .valid         (valid),
      .total         (total),
      .arg_0_raddr_0 (arg_0_raddr_0),
      .arg_0_rdata_0 (arg_0_rdata_0),
      .arg_0_waddr_0 (arg_0_waddr_0),
      .arg_0_wdata_0 (arg_0_wdata_0),
      .arg_0_wen_0   (arg_0_wen_0),
      .arg_1_waddr_0 (arg_1_waddr_0),
      .arg_1_wdata_0 (arg_1_wdata_0),
      .arg_1_wen_0   (arg_1_wen_0)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural RAMs ----------------
   bin_cnt_t hist      [NB];
   bin_cnt_t hist_init [NB];
   bin_cnt_t cdf       [NB];
   logic     load_hist = 1'b0;
   int       wr_count  = 0;
   int       wr_mark   = 0;
   int       first_wr  = -1;
   int       last_wr   = -1;
   logic     a0_wen_seen = 1'b0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      arg_0_rdata_0 <= hist[arg_0_raddr_0];
      if (arg_1_wen_0) begin
         cdf[arg_1_waddr_0] <= arg_1_wdata_0;
         if (wr_count == wr_mark) first_wr = cyc;
         last_wr  = cyc;
         wr_count = wr_count + 1;
      end
      if (arg_0_wen_0) begin
         hist[arg_0_waddr_0] <= arg_0_wdata_0;
         a0_wen_seen = 1'b1;
      end
      if (load_hist) begin
         for (int k = 0; k < NB; k++) hist[k] <= hist_init[k];
      end
   end

   // ---------------- reference model ----------------
   // m_t = cycle index relative to the cycle in which the accepted start was high.
   bin_cnt_t m_pre [NB];
   bin_cnt_t m_hold   = '0;
   bin_cnt_t m_run;
   logic     m_active = 1'b0;
   int       m_t      = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_active = 1'b0;
         m_hold   = '0;
         m_t      = 0;
      end else begin
         if (start && !(m_active && m_t >= 1 && m_t <= NB + 1)) begin
            if (m_active && m_t >= NB + 2) m_hold = m_pre[NB-1];
            m_run = '0;
            for (int k = 0; k < NB; k++) begin
               m_run    = m_run + hist[k];
               m_pre[k] = m_run;
            end
            m_active = 1'b1;
            m_t      = 1;
         end else if (m_active) begin
            m_t = m_t + 1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic e_rd, e_wr, e_val;
   int   e_idx;

   always @(negedge clk) begin
      if (chk_en) begin
         e_rd  = m_active && m_t >= 1 && m_t <= NB;
         e_wr  = m_active && m_t >= 2 && m_t <= NB + 1;
         e_val = m_active && m_t >= NB + 2;
         e_idx = e_wr ? m_t - 2 : 0;
         check("valid", 64'(valid), 64'(e_val));
         check("total", 64'(total), 64'(e_val ? m_pre[NB-1] : m_hold));
         check("raddr", 64'(arg_0_raddr_0), e_rd ? 64'(m_t - 1) : 64'd0);
         check("cdf_wen", 64'(arg_1_wen_0), 64'(e_wr));
         check("cdf_waddr", 64'(arg_1_waddr_0), e_wr ? 64'(e_idx) : 64'd0);
         check("cdf_wdata", 64'(arg_1_wdata_0), e_wr ? 64'(m_pre[e_idx]) : 64'd0);
`ifdef HISTOGRAM_CDF_CLEAR_EN
         check("hist_wen", 64'(arg_0_wen_0), 64'(e_wr));
         check("hist_waddr", 64'(arg_0_waddr_0), e_wr ? 64'(e_idx) : 64'd0);
`else
         check("hist_wen", 64'(arg_0_wen_0), 64'd0);
         check("hist_waddr", 64'(arg_0_waddr_0), 64'd0);
`endif
         check("hist_wdata", 64'(arg_0_wdata_0), 64'd0);
      end
   end

   // ---------------- helpers ----------------
   // mode: 0 zero, 1 ramp, 2 only last bin = 4096, 3 all 7, 4 random full range, 5 random small
   task automatic fill(input int mode);
      for (int k = 0; k < NB; k++) begin
         case (mode)
            0:       hist_init[k] = '0;
            1:       hist_init[k] = bin_cnt_t'(k);
            2:       hist_init[k] = (k == NB - 1) ? bin_cnt_t'(4096) : '0;
            3:       hist_init[k] = bin_cnt_t'(7);
            4:       hist_init[k] = bin_cnt_t'($urandom);
            default: hist_init[k] = bin_cnt_t'($urandom_range(1000));
         endcase
      end
      @(posedge clk); #1 load_hist = 1'b1;
      @(posedge clk); #1 load_hist = 1'b0;
   endtask

   function automatic bin_cnt_t init_sum();
      bin_cnt_t s = '0;
      for (int k = 0; k < NB; k++) s = s + hist_init[k];
      return s;
   endfunction

   task automatic pulse_start(output int s);
      @(posedge clk); #1;
      start   = 1'b1;
      s       = cyc;
      wr_mark = wr_count;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Start, then random start pulses through RUN and DRAIN (all must be ignored).
   task automatic noisy_start(output int s);
      @(posedge clk); #1;
      start   = 1'b1;
      s       = cyc;
      wr_mark = wr_count;
      for (int c = 0; c < NB + 1; c++) begin
         @(posedge clk); #1;
         start = ($urandom_range(15) == 0);
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_valid(input int s, input string name);
      int n = 0;
      @(negedge clk);
      while (!valid && n < 400) begin
         @(negedge clk);
         n = n + 1;
      end
      check({name, "_valid_seen"}, 64'(valid), 64'd1);
      if (valid) check({name, "_latency"}, 64'(cyc - s), 64'(NB + 2));
   endtask

   task automatic cmp_cdf(input string name);
      for (int k = 0; k < NB; k++) check({name, "_cdf"}, 64'(cdf[k]), 64'(m_pre[k]));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int       s, s2, nz;
      bin_cnt_t esum;
      rst   = 1'b0;
      start = 1'b0;
      repeat (3) @(posedge clk);
      chk_en = 1'b1;
      #1;
      check("reset_valid", 64'(valid), 64'd0);
      check("reset_total", 64'(total), 64'd0);
      check("reset_cdf_wen", 64'(arg_1_wen_0), 64'd0);
      check("reset_raddr", 64'(arg_0_raddr_0), 64'd0);
      @(posedge clk); #1 rst = 1'b1;

      // All-zero histogram
      fill(0);
      pulse_start(s);
      wait_valid(s, "zero");
      check("zero_total", 64'(total), 64'd0);
      check("zero_writes", 64'(wr_count - wr_mark), 64'd256);
      check("zero_cdf255", 64'(cdf[NB-1]), 64'd0);

      // Ramp: bin k = k
      fill(1);
      pulse_start(s);
      wait_valid(s, "ramp");
      check("ramp_cdf255", 64'(cdf[255]), 64'd32640);
      check("ramp_cdf10", 64'(cdf[10]), 64'd55);
      check("ramp_total", 64'(total), 64'd32640);
      cmp_cdf("ramp");

      // Only the last bin populated
      fill(2);
      pulse_start(s);
      wait_valid(s, "last");
      check("last_cdf254", 64'(cdf[254]), 64'd0);
      check("last_cdf255", 64'(cdf[255]), 64'd4096);
      check("last_first_wr", 64'(first_wr - s), 64'd2);
      check("last_last_wr", 64'(last_wr - s), 64'd257);

      // start pulsed during RUN and DRAIN, then a restart from DONE
      fill(5);
      esum = init_sum();
      @(posedge clk); #1;
      start   = 1'b1;
      s       = cyc;
      wr_mark = wr_count;
      while (cyc < s + 257) begin
         @(posedge clk); #1;
         start = (cyc == s + 1) || (cyc == s + 100) || (cyc == s + 256) || (cyc == s + 257);
      end
      @(posedge clk); #1 start = 1'b0;
      wait_valid(s, "ignore");
      check("ignore_writes", 64'(wr_count - wr_mark), 64'd256);
      check("ignore_total", 64'(total), 64'(esum));
      pulse_start(s2);
      check("restart_valid_low", 64'(valid), 64'd0);
      wait_valid(s2, "restart");
`ifdef HISTOGRAM_CDF_CLEAR_EN
      check("restart_total", 64'(total), 64'd0);
`else
      check("restart_total", 64'(total), 64'(esum));
`endif

      // Reset in the middle of a sweep
      fill(1);
      pulse_start(s);
      while (cyc < s + 100) begin
         @(posedge clk); #1;
      end
      rst = 1'b0;
      #1;
      check("midrst_valid", 64'(valid), 64'd0);
      check("midrst_cdf_wen", 64'(arg_1_wen_0), 64'd0);
      check("midrst_hist_wen", 64'(arg_0_wen_0), 64'd0);
      check("midrst_raddr", 64'(arg_0_raddr_0), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      fill(4);
      esum = init_sum();
      pulse_start(s);
      wait_valid(s, "postrst");
      check("postrst_total", 64'(total), 64'(esum));
      cmp_cdf("postrst");

      // All bins = 7: clearing behaviour
      fill(3);
      pulse_start(s);
      wait_valid(s, "seven");
      check("seven_cdf255", 64'(cdf[255]), 64'd1792);
      check("seven_total", 64'(total), 64'd1792);
      nz = 0;
      for (int k = 0; k < NB; k++) begin
`ifdef HISTOGRAM_CDF_CLEAR_EN
         if (hist[k] != '0) nz = nz + 1;
`else
         if (hist[k] != bin_cnt_t'(7)) nz = nz + 1;
`endif
      end
      check("seven_hist_after", 64'(nz), 64'd0);
`ifdef HISTOGRAM_CDF_CLEAR_EN
      check("seven_hist_wen_seen", 64'(a0_wen_seen), 64'd1);
`else
      check("seven_hist_wen_seen", 64'(a0_wen_seen), 64'd0);
`endif

      // Randomized sweeps with spurious starts
      for (int r = 0; r < 6; r++) begin
         fill((r % 2 == 0) ? 4 : 5);
         esum = init_sum();
         noisy_start(s);
         wait_valid(s, "rand");
         check("rand_writes", 64'(wr_count - wr_mark), 64'd256);
         check("rand_total", 64'(total), 64'(esum));
         cmp_cdf("rand");
      end

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
